// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the ALU pipe: op codes, controller states, flag bundle.
package alu_pipe_pkg;

  localparam int OP_W = 4;

  // Codes 0-7 keep their original 3-bit meaning; 8-10 are the extensions.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NAND = 4'd2,
    OP_XOR  = 4'd3,
    OP_INC  = 4'd4,
    OP_SRA  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLL  = 4'd7,
    OP_ROL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
    logic err;
  } alu_flags_t;

  // Anything above MUL is an unassigned code.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH cycles per product. done_o is asserted during the last step and
// product_o then carries the finished 2*WIDTH-bit product.
module alu_mul_iter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic               busy_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplr_q;

  assign acc_d     = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == SHW'(WIDTH - 1));
  assign product_o = acc_d;

  // Load operands on start, then add one shifted partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= {{WIDTH{1'b0}}, op_a_i};
      mplr_q  <= op_b_i;
    end else if (busy_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + SHW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-slot ALU with valid/ready handshakes on both sides. Non-MUL ops
// finish in one cycle; MUL runs on the iterative multiplier for WIDTH cycles.
//
// state   | meaning
// IDLE    | empty, ready for a request
// MUL     | multiplier stepping, input stalled
// DONE    | result valid and held until out_ready
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             err
);

  alu_state_e         state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  alu_flags_t         flags_q;

  logic [WIDTH-1:0]   res_d;
  alu_flags_t         flags_d;

  logic               accept;
  logic               is_mul;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_fin;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SHW-1:0]     amt;
  logic [SHW:0]       inv_amt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rol;
  logic [WIDTH-1:0]   ror;

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_op == OP_MUL);
  assign mul_fin  = mul_busy && mul_done;

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign z          = flags_q.z;
  assign v          = flags_q.v;
  assign n          = flags_q.n;
  assign err        = flags_q.err;

  // Only the low SHW bits of B steer shifts; inv_amt (1..WIDTH) supplies the
  // wrap-around half of a rotate and shifts everything out when amt is 0.
  assign amt     = alu_b[SHW-1:0];
  assign inv_amt = (SHW+1)'(WIDTH) - {1'b0, amt};
  assign sum     = alu_a + alu_b;
  assign diff    = alu_a - alu_b;
  assign rol     = (alu_a << amt) | (alu_a >> inv_amt);
  assign ror     = (alu_a >> amt) | (alu_a << inv_amt);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && is_mul),
    .op_a_i    (alu_a),
    .op_b_i    (alu_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Single-cycle result and flags for every op except MUL.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (alu_op)
      OP_ADD, OP_INC: begin
        res_d     = sum;
        flags_d.n = sum[WIDTH-1];
        flags_d.v = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d     = diff;
        flags_d.n = diff[WIDTH-1];
        flags_d.v = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_NAND: res_d = ~(alu_a & alu_b);
      OP_XOR:  res_d = alu_a ^ alu_b;
      OP_SRA:  res_d = $signed(alu_a) >>> amt;
      OP_SRL:  res_d = alu_a >> amt;
      OP_SLL:  res_d = alu_a << amt;
      OP_ROL:  res_d = rol;
      OP_ROR:  res_d = ror;
      default: res_d = '0;
    endcase
    flags_d.err = !op_is_legal(alu_op);
    flags_d.z   = (res_d == '0);
  end

  // Controller: accept, step the multiplier, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (accept) begin
      if (is_mul) begin
        state_q     <= ST_MUL;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= ST_DONE;
        out_valid_q <= 1'b1;
        result_q    <= res_d;
        flags_q     <= flags_d;
      end
    end else begin
      case (state_q)
        ST_MUL: begin
          if (mul_fin) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[WIDTH-1:0];
            flags_q.z   <= (mul_prod[WIDTH-1:0] == '0);
            flags_q.v   <= |mul_prod[2*WIDTH-1:WIDTH];
            flags_q.n   <= 1'b0;
            flags_q.err <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal values 8, 16, 32).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; not overridden independently.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 alu_op  input  4  operation code, sampled on acceptance.
REQ-008 alu_a  input  WIDTH  operand A, sampled on acceptance.
REQ-009 alu_b  input  WIDTH  operand B, sampled on acceptance.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 alu_result  output  WIDTH  registered result.
REQ-013 z, v, n, err  output  1 each  registered zero, overflow, negative, illegal-op flags.

Function
REQ-014 The block SHALL accept a request when in_valid and in_ready are both high on a rising edge.
REQ-015 Op codes SHALL be: 0 ADD, 1 SUB, 2 NAND, 3 XOR, 4 INC (a+b), 5 SRA, 6 SRL, 7 SLL, 8 ROL, 9 ROR, 10 MUL, 11-15 illegal.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH; shifts and rotates SHALL use only alu_b[SHW-1:0] as the amount.
REQ-017 MUL SHALL be unsigned iterative shift-add, one partial-product bit per cycle; result is low WIDTH bits of the 2*WIDTH-bit product.
REQ-018 FSM states SHALL be IDLE, MUL, DONE; reset state IDLE.
REQ-019 IDLE: in_ready=1; on acceptance of a non-MUL op go to DONE with result and flags registered; of MUL go to MUL with counter cleared.
REQ-020 MUL: in_ready=0; stay exactly WIDTH cycles, then go to DONE with result and flags registered.
REQ-021 DONE: out_valid=1; outputs held stable while out_ready=0; on out_ready=1 go to IDLE, or accept a new request in the same cycle.
REQ-022 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-023 Latency SHALL be 1 cycle for non-MUL ops and WIDTH+1 cycles for MUL, acceptance edge to out_valid.
REQ-024 Back-to-back non-MUL ops with out_ready held high SHALL sustain one result per cycle.
REQ-025 z SHALL be high iff alu_result is all zeros, for every op.
REQ-026 n SHALL equal alu_result[WIDTH-1] for ADD, SUB, INC and be 0 otherwise.
REQ-027 v SHALL be signed overflow for ADD/INC (equal operand signs, differing result sign), for SUB (differing operand signs, result sign differs from A), nonzero upper product half for MUL, and 0 otherwise.
REQ-028 Illegal ops SHALL complete with 1-cycle latency: alu_result=0, z=1, v=0, n=0, err=1; err SHALL be 0 for legal ops.
REQ-029 Shift/rotate by amount 0 SHALL return alu_a unchanged.

Reset
REQ-030 While rst_n is low: state=IDLE, out_valid=0, alu_result=0, z=0, v=0, n=0, err=0, MUL counter and accumulator=0.
REQ-031 Reset asserted mid-MUL or in DONE SHALL discard the operation; no result is produced after release.
REQ-032 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-033 Op-code constants and the FSM state encoding SHALL live in the shared alu_ops package/header, extended from 3-bit to 4-bit codes with 0-7 unchanged.
REQ-034 The iterative multiplier SHALL be a sub-module alu_mul_iter (start, busy, done, WIDTH-parametrised); all other ops are combinational inside alu_pipe.

Verification (WIDTH=16)
REQ-035 ADD 0x7FFF+0x0001, out_ready=1 -> out_valid next cycle, result 0x8000, n=1, v=1, z=0, err=0.
REQ-036 MUL 0x0100*0x0100 -> out_valid exactly 17 cycles after acceptance, result 0x0000, z=1, v=1; in_ready=0 throughout MUL.
REQ-037 SRA 0x8000 with b=0x0013 -> result 0xF000 (amount 3); ROL 0x8001 by 1 -> 0x0003.
REQ-038 SUB 0x0005-0x0005 then out_ready=0 for 3 cycles -> result 0x0000, z=1 held stable, in_ready=0 until out_ready rises.
REQ-039 Op 0xC with any operands -> result 0, z=1, err=1, 1-cycle latency.
REQ-040 rst_n pulsed low 5 cycles into MUL -> out_valid stays 0, in_ready=1 after release, next ADD 2+3 returns 0x0005.
